// File: rtl/prog_delay_line.sv
// Programmable sample delay line: a MAX_DEPTH-entry circular buffer that
// re-emits each accepted sample after D further accepts, flushing on cfg_load.
module prog_delay_line #(
    parameter int WIDTH         = 8,
    parameter int MAX_DEPTH     = 32,
    parameter int DEFAULT_DELAY = 30,
    localparam int DW           = $clog2(MAX_DEPTH + 1),
    localparam int AW           = $clog2(MAX_DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             cfg_load,
    input  logic [DW-1:0]    delay_cfg,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             primed,
    output logic [DW-1:0]    active_delay
);

    localparam logic [DW-1:0] MAX_D     = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] DEF_D     = DW'(DEFAULT_DELAY);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_DEPTH - 1);

    logic [WIDTH-1:0] mem_q [MAX_DEPTH];

    logic [AW-1:0]    wptr_q, wptr_d, wptr_next;
    logic [DW-1:0]    fill_q, fill_d;
    logic [DW-1:0]    delay_q, delay_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;

    logic [DW-1:0]    wptr_ext;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [DW-1:0]    cfg_clamped;
    logic             full;
    logic             wr_en;

    assign full     = (fill_q == delay_q);
    assign wptr_ext = DW'(wptr_q);

    // The wrap term stays below MAX_DEPTH, so modular DW-bit arithmetic is exact.
    assign rd_addr   = (wptr_ext >= delay_q) ? AW'(wptr_ext - delay_q)
                                             : AW'(wptr_ext + MAX_D - delay_q);
    assign rd_data   = mem_q[rd_addr];
    assign wptr_next = (wptr_q == LAST_ADDR) ? '0 : wptr_q + AW'(1);

    always_comb begin
        if (delay_cfg == '0) begin
            cfg_clamped = DW'(1);
        end else if (delay_cfg > MAX_D) begin
            cfg_clamped = MAX_D;
        end else begin
            cfg_clamped = delay_cfg;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        wptr_d      = wptr_q;
        fill_d      = fill_q;
        delay_d     = delay_q;
        out_valid_d = 1'b0;
        data_out_d  = '0;
        wr_en       = 1'b0;
        if (cfg_load) begin
            delay_d = cfg_clamped;
            if (in_valid) begin
                wr_en  = 1'b1;
                wptr_d = wptr_next;
                fill_d = DW'(1);
            end else begin
                fill_d = '0;
            end
        end else if (in_valid) begin
            wr_en  = 1'b1;
            wptr_d = wptr_next;
            fill_d = full ? fill_q : fill_q + DW'(1);
            if (full) begin
                out_valid_d = 1'b1;
                data_out_d  = rd_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q      <= '0;
            fill_q      <= '0;
            delay_q     <= DEF_D;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            fill_q      <= fill_d;
            delay_q     <= delay_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    // NOTE: the buffer is deliberately not reset; out_valid gating keeps stale entries hidden.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wptr_q] <= data_in;
        end
    end

    assign out_valid    = out_valid_q;
    assign data_out     = data_out_q;
    assign primed       = full;
    assign active_delay = delay_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboard bench for prog_delay_line: a default-parameter instance checked
// every cycle against a sample-history model, plus a 12-bit, depth-5 instance.
module tb_prog_delay_line;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       p;
        logic [5:0] ad;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid, cfg_load;
    logic [7:0] data_in;
    logic [5:0] delay_cfg;
    logic       out_valid, primed;
    logic [7:0] data_out;
    logic [5:0] active_delay;

    logic        in_valid5, cfg_load5;
    logic [11:0] data_in5;
    logic [2:0]  delay_cfg5;
    logic        out_valid5, primed5;
    logic [11:0] data_out5;
    logic [2:0]  active_delay5;

    int checks = 0;
    int errors = 0;

    exp_t       sb[$];
    logic [7:0] hist[$];
    int         model_d = 30;

    always #5 clock = ~clock;

    prog_delay_line dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .data_in(data_in),
        .cfg_load(cfg_load), .delay_cfg(delay_cfg),
        .out_valid(out_valid), .data_out(data_out),
        .primed(primed), .active_delay(active_delay)
    );

    prog_delay_line #(.WIDTH(12), .MAX_DEPTH(5), .DEFAULT_DELAY(5)) dut5 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid5), .data_in(data_in5),
        .cfg_load(cfg_load5), .delay_cfg(delay_cfg5),
        .out_valid(out_valid5), .data_out(data_out5),
        .primed(primed5), .active_delay(active_delay5)
    );

    // Scoreboard: one expectation is pushed per clock edge driven by step().
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ({out_valid, data_out, primed, active_delay} !== {e.v, e.d, e.p, e.ad}) begin
                errors++;
                $display("FAIL scoreboard t=%0t got v=%b d=%h p=%b ad=%0d expected v=%b d=%h p=%b ad=%0d",
                         $time, out_valid, data_out, primed, active_delay, e.v, e.d, e.p, e.ad);
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] din, input logic cl, input logic [5:0] cfg);
        exp_t e;
        in_valid  = v;
        data_in   = din;
        cfg_load  = cl;
        delay_cfg = cfg;
        e = '0;
        if (cl) begin
            model_d = (cfg == 0) ? 1 : ((cfg > 32) ? 32 : int'(cfg));
            hist.delete();
            if (v) hist.push_back(din);
        end else if (v) begin
            if (hist.size() >= model_d) begin
                e.v = 1'b1;
                e.d = hist[hist.size() - model_d];
            end
            hist.push_back(din);
        end
        e.p  = (hist.size() >= model_d);
        e.ad = 6'(model_d);
        @(posedge clock);
        sb.push_back(e);
        @(negedge clock);
        in_valid = 1'b0;
        cfg_load = 1'b0;
        data_in  = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b0; cfg_load = 1'b0; data_in = '0; delay_cfg = '0;
        in_valid5 = 1'b0; cfg_load5 = 1'b0; data_in5 = '0; delay_cfg5 = '0;
        repeat (2) @(negedge clock);
        checks++;
        if ({out_valid, data_out, primed, active_delay} !== {1'b0, 8'h00, 1'b0, 6'd30}) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%h p=%b ad=%0d expected 0 00 0 30",
                     out_valid, data_out, primed, active_delay);
        end
        #1 reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_default_stream();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(i + 1), 1'b0, '0);
            checks++;
            if (out_valid !== (i >= 30) || primed !== (i >= 29)) begin
                errors++;
                $display("FAIL default_latency accept=%0d got v=%b p=%b expected v=%b p=%b",
                         i, out_valid, primed, (i >= 30), (i >= 29));
            end
        end
    endtask

    task automatic test_delay_one();
        step(1'b0, '0, 1'b1, 6'd1);
        checks++;
        if (active_delay !== 6'd1) begin
            errors++;
            $display("FAIL delay_one_cfg got ad=%0d expected 1", active_delay);
        end
        step(1'b1, 8'hA0, 1'b0, '0);
        repeat (3) step(1'b0, '0, 1'b0, '0);
        step(1'b1, 8'hA1, 1'b0, '0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'hA0) begin
            errors++;
            $display("FAIL delay_one_out got v=%b d=%h expected 1 a0", out_valid, data_out);
        end
        repeat (3) step(1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_clamp_and_wrap();
        int seen;
        seen = 0;
        step(1'b0, '0, 1'b1, 6'd0);
        checks++;
        if (active_delay !== 6'd1) begin
            errors++;
            $display("FAIL clamp_zero got ad=%0d expected 1", active_delay);
        end
        step(1'b0, '0, 1'b1, 6'd40);
        checks++;
        if (active_delay !== 6'd32) begin
            errors++;
            $display("FAIL clamp_high got ad=%0d expected 32", active_delay);
        end
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0, '0);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 32) begin
            errors++;
            $display("FAIL wrap_count got %0d outputs expected 32", seen);
        end
    endtask

    task automatic test_reload_primed();
        step(1'b0, '0, 1'b1, 6'd4);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, '0);
        checks++;
        if (primed !== 1'b1) begin
            errors++;
            $display("FAIL reload_primed got p=%b expected 1", primed);
        end
        step(1'b1, 8'h55, 1'b1, 6'd2);
        checks++;
        if (out_valid !== 1'b0 || active_delay !== 6'd2) begin
            errors++;
            $display("FAIL reload_cycle got v=%b ad=%0d expected 0 2", out_valid, active_delay);
        end
        step(1'b1, 8'h66, 1'b0, '0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reload_no_stale got v=%b d=%h expected 0", out_valid, data_out);
        end
        step(1'b1, 8'h77, 1'b0, '0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'h55) begin
            errors++;
            $display("FAIL reload_out got v=%b d=%h expected 1 55", out_valid, data_out);
        end
    endtask

    task automatic test_midstream_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, '0);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, data_out, primed, active_delay} !== {1'b0, 8'h00, 1'b0, 6'd30}) begin
            errors++;
            $display("FAIL async_reset got v=%b d=%h p=%b ad=%0d expected 0 00 0 30",
                     out_valid, data_out, primed, active_delay);
        end
        hist.delete();
        model_d = 30;
        @(negedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b0, '0);
            checks++;
            if (out_valid !== (i >= 30)) begin
                errors++;
                $display("FAIL post_reset_latency accept=%0d got v=%b expected %b", i, out_valid, (i >= 30));
            end
        end
    endtask

    task automatic test_non_pow2();
        logic [11:0] h[$];
        logic        ev;
        logic [11:0] ed;
        int          accepts;
        accepts = 0;
        checks++;
        if (active_delay5 !== 3'd5) begin
            errors++;
            $display("FAIL np2_delay got ad=%0d expected 5", active_delay5);
        end
        for (int i = 0; i < 400 && accepts < 50; i++) begin
            in_valid5 = ($urandom_range(0, 3) != 0);
            data_in5  = 12'($urandom);
            ev = 1'b0;
            ed = '0;
            if (in_valid5) begin
                if (h.size() >= 5) begin
                    ev = 1'b1;
                    ed = h[h.size() - 5];
                end
                h.push_back(data_in5);
                accepts++;
            end
            @(posedge clock);
            @(negedge clock);
            checks++;
            if (out_valid5 !== ev || data_out5 !== ed) begin
                errors++;
                $display("FAIL np2_stream cycle=%0d got v=%b d=%h expected v=%b d=%h",
                         i, out_valid5, data_out5, ev, ed);
            end
        end
        in_valid5 = 1'b0;
        checks++;
        if (accepts != 50) begin
            errors++;
            $display("FAIL np2_budget got %0d accepts expected 50", accepts);
        end
    endtask

    initial begin
        test_reset();
        test_default_stream();
        test_delay_one();
        test_clamp_and_wrap();
        test_reload_primed();
        test_midstream_reset();
        test_non_pow2();
        @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
